// File: rtl/config_bus_arbiter.sv
// config_bus_arbiter
//   Round-robin arbiter that lets num_req requesters share one GPIO-driven
//   configuration bus. The granted write is serialised MSB-byte first. Each
//   byte gets one setup cycle, then hold_cycles cycles with w_clk high, then
//   hold_cycles cycles with w_clk low.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req_valid   [num_req]     per-requester write request
//   req_addr    [num_req*16]  bus address, requester i at [16i+:16]
//   req_data    [num_req*32]  payload, requester i at [32i+:32]
//   req_nbytes  [num_req*3]   byte count (0 = no bus activity, >4 = 4)
//   req_ready   [num_req]     one-cycle accept pulse to the granted requester
//   done        [num_req]     one-cycle completion pulse
//   busy        high whenever the FSM is not idle
//   gpio_out    [15:0] addr, [23:16] data byte, [24] w_clk, [31:25] zero
module config_bus_arbiter #(
    parameter int num_req     = 2,
    parameter int hold_cycles = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [num_req-1:0]     req_valid,
    input  logic [num_req*16-1:0]  req_addr,
    input  logic [num_req*32-1:0]  req_data,
    input  logic [num_req*3-1:0]   req_nbytes,
    output logic [num_req-1:0]     req_ready,
    output logic [num_req-1:0]     done,
    output logic                   busy,
    output logic [31:0]            gpio_out
);

    localparam int GW = $clog2(num_req);
    localparam int CW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    localparam logic [GW-1:0]      LAST_INIT = GW'(num_req - 1);
    localparam logic [CW-1:0]      HOLD_LAST = CW'(hold_cycles - 1);
    localparam logic [num_req-1:0] ONE_HOT0  = {{(num_req-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOV, DONE} state_t;

    state_t          r_state, w_next;
    logic [GW-1:0]   r_last_grant, r_grant, w_grant;
    logic            w_any;
    logic [15:0]     w_sel_addr;
    logic [31:0]     w_sel_data, w_aligned;
    logic [2:0]      w_sel_nb, w_nb;
    logic [5:0]      w_shamt;
    logic [CW-1:0]   r_cnt;
    logic            w_cnt_end;
    logic [1:0]      r_left;      // bytes still to send after the current one
    logic [31:0]     r_shift;     // pending bytes, next one in [31:24]
    logic [15:0]     r_bus_addr;
    logic [7:0]      r_bus_byte;

    // Round robin: scan offsets num_req..1 so the smallest offset from
    // last_grant that is requesting wins the final assignment.
    always_comb begin
        logic [GW-1:0] w_idx;
        w_grant = '0;
        for (int k = num_req; k >= 1; k--) begin
            w_idx = GW'((int'(r_last_grant) + k) % num_req);
            if (req_valid[w_idx]) w_grant = w_idx;
        end
    end

    assign w_any      = |req_valid;
    assign w_sel_addr = req_addr[int'(w_grant)*16 +: 16];
    assign w_sel_data = req_data[int'(w_grant)*32 +: 32];
    assign w_sel_nb   = req_nbytes[int'(w_grant)*3 +: 3];
    assign w_nb       = (w_sel_nb > 3'd4) ? 3'd4 : w_sel_nb;
    // Left-justify the payload so the first byte to send sits in [31:24].
    assign w_shamt    = {3'd4 - w_nb, 3'b000};
    assign w_aligned  = w_sel_data << w_shamt;
    assign w_cnt_end  = (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = (w_nb == 3'd0) ? DONE : SETUP;
            SETUP:   w_next = STROBE;
            STROBE:  if (w_cnt_end) w_next = RECOV;
            RECOV:   if (w_cnt_end) w_next = (r_left != 2'd0) ? SETUP : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= LAST_INIT;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_left       <= '0;
            r_shift      <= '0;
            r_bus_addr   <= '0;
            r_bus_byte   <= '0;
        end else begin
            if ((r_state == STROBE || r_state == RECOV) && !w_cnt_end)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            case (r_state)
                IDLE: if (w_any) begin
                    r_grant <= w_grant;
                    r_left  <= (w_nb == 3'd0) ? 2'd0 : 2'(w_nb - 3'd1);
                    r_shift <= w_aligned << 8;
                    // A zero-length write must not disturb the bus lines.
                    if (w_nb != 3'd0) begin
                        r_bus_addr <= w_sel_addr;
                        r_bus_byte <= w_aligned[31:24];
                    end
                end
                RECOV: if (w_cnt_end && r_left != 2'd0) begin
                    r_bus_byte <= r_shift[31:24];
                    r_shift    <= r_shift << 8;
                    r_left     <= r_left - 2'd1;
                end
                DONE: r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    // req_ready is gated by rst so it is low the instant reset asserts.
    assign req_ready = (r_state == IDLE && w_any && rst) ? (ONE_HOT0 << w_grant) : '0;
    assign done      = (r_state == DONE) ? (ONE_HOT0 << r_grant) : '0;
    assign busy      = (r_state != IDLE);
    assign gpio_out  = {7'b0, (r_state == STROBE), r_bus_byte, r_bus_addr};

endmodule

// File: tb/tb_config_bus_arbiter.sv
module tb_config_bus_arbiter;

    localparam int NREQ = 3;
    localparam int HOLD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*16-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*3-1:0] req_nbytes;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [31:0]       gpio_out;

    config_bus_arbiter #(.num_req(NREQ), .hold_cycles(HOLD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_nbytes(req_nbytes), .req_ready(req_ready),
        .done(done), .busy(busy), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0]           mask;
        logic [NREQ-1:0][15:0]     addr;
        logic [NREQ-1:0][31:0]     data;
        logic [NREQ-1:0][2:0]      nb;
        int                        exp_grant;
        int                        exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
    } ent_t;

    int tests = 0;
    int fails = 0;
    int m_last = NREQ - 1;

    // Bus observer: one entry per w_clk pulse, plus its high width.
    ent_t        bq[$];
    int          wq[$];
    logic [31:0] cfg = '0;
    int          done_cnt = 0;
    bit          bad_ready = 0, bad_wclk = 0, bad_hi = 0;
    bit          prev_w = 0;
    int          hcnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_w = 0;
            hcnt   = 0;
        end else begin
            if (gpio_out[24]) begin
                if (!prev_w) begin
                    bq.push_back('{a: gpio_out[15:0], b: gpio_out[23:16]});
                    cfg = {cfg[23:0], gpio_out[23:16]};
                end
                hcnt++;
                if (!busy) bad_wclk = 1;
            end else if (prev_w) begin
                wq.push_back(hcnt);
                hcnt = 0;
            end
            if (!$onehot0(req_ready)) bad_ready = 1;
            if (gpio_out[31:25] != 7'd0) bad_hi = 1;
            if (done != '0) done_cnt++;
            prev_w = gpio_out[24];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int clampn(input logic [2:0] n);
        return (n > 3'd4) ? 4 : int'(n);
    endfunction

    function automatic int rr(input logic [NREQ-1:0] mask, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic vec_t mk(input logic [NREQ-1:0] mask, input logic [15:0] a,
                                input logic [31:0] d, input logic [2:0] n,
                                input int g, input int lat);
        vec_t v;
        for (int i = 0; i < NREQ; i++) begin
            v.addr[i] = 16'hF000 | 16'(i);
            v.data[i] = 32'hDEAD0000 | 32'(i);
            v.nb[i]   = 3'd1;
        end
        v.mask = mask; v.addr[g] = a; v.data[g] = d; v.nb[g] = n;
        v.exp_grant = g; v.exp_lat = lat;
        return v;
    endfunction

    task automatic wait_ready(output int g, output bit ok);
        ok = 0; g = -1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int g, lat, n, bb, wb;
        bit ok, rdy_busy;
        logic [31:0] d;
        logic [7:0]  lastb;
        bb = bq.size(); wb = wq.size();
        @(negedge clk);
        req_valid = v.mask; req_addr = v.addr; req_data = v.data; req_nbytes = v.nb;
        wait_ready(g, ok);
        if (!ok) begin
            chk({nm, "_ready_timeout"}, 0, 1);
            req_valid = '0;
            return;
        end
        chk({nm, "_grant"}, g, v.exp_grant);
        lat = 0; rdy_busy = 0;
        do begin
            @(negedge clk); lat++; #1;
            if (done == '0) begin
                if (req_ready != '0) rdy_busy = 1;
                req_valid = NREQ'($urandom);
            end
        end while (done == '0 && lat < 200);
        req_valid = '0;
        chk({nm, "_latency"}, lat, v.exp_lat);
        chk({nm, "_done"}, done, 3'b001 << v.exp_grant);
        chk({nm, "_ready_while_busy"}, rdy_busy, 0);
        n = clampn(v.nb[v.exp_grant]);
        d = v.data[v.exp_grant];
        chk({nm, "_nbytes_on_bus"}, bq.size() - bb, n);
        chk({nm, "_npulse_widths"}, wq.size() - wb, n);
        for (int b = 0; b < n && bb + b < bq.size(); b++) begin
            chk({nm, "_byte"}, bq[bb+b].b, 8'(d >> (8 * (n - 1 - b))));
            chk({nm, "_addr"}, bq[bb+b].a, v.addr[v.exp_grant]);
        end
        for (int b = 0; b < n && wb + b < wq.size(); b++)
            chk({nm, "_wclk_width"}, wq[wb+b], HOLD);
        if (n > 0) begin
            lastb = 8'(d);
            chk({nm, "_bus_hold"}, gpio_out, {8'h00, lastb, v.addr[v.exp_grant]});
        end
        m_last = v.exp_grant;
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        int g, dc0, n;
        bit ok;
        logic [NREQ-1:0] mask;

        // Expected grants follow round robin from last_grant = 2 after reset.
        tbl[0] = mk(3'b001, 16'h0003, 32'hAABBCCDD, 3'd4, 0, 21);
        tbl[1] = mk(3'b011, 16'h0010, 32'h11223344, 3'd2, 1, 11);
        tbl[2] = mk(3'b011, 16'h0020, 32'h55667788, 3'd0, 0, 1);
        tbl[3] = mk(3'b111, 16'h0030, 32'h0A0B0C0D, 3'd7, 1, 21);
        tbl[4] = mk(3'b111, 16'h0040, 32'h000000EE, 3'd1, 2, 6);
        tbl[5] = mk(3'b101, 16'h0050, 32'h99887766, 3'd5, 0, 21);
        tbl[6] = mk(3'b100, 16'h0060, 32'h00ABCDEF, 3'd3, 2, 16);
        tbl[7] = mk(3'b110, 16'h0070, 32'h00001234, 3'd2, 1, 11);

        rst = 1'b0;
        req_valid = '1; req_addr = '1; req_data = '1; req_nbytes = '1;
        #3;
        chk("reset_ready", req_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_gpio", gpio_out, 0);
        req_valid = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
            if (i == 7) chk("cfg_reg_low16", cfg[15:0], 16'h1234);
        end

        // Both low requesters hammering: must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++)
            run_txn(mk(3'b011, 16'h0100, 32'h000000A5, 3'd1, i % 2, 6),
                    $sformatf("alt%0d", i));

        // Abort a write in the strobe phase of its second byte.
        dc0 = done_cnt;
        v = mk(3'b001, 16'h0077, 32'hCAFEF00D, 3'd4, 0, 21);
        @(negedge clk);
        req_valid = v.mask; req_addr = v.addr; req_data = v.data; req_nbytes = v.nb;
        wait_ready(g, ok);
        chk("abort_grant", ok ? g : -1, 0);
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_in_strobe", gpio_out[24], 1'b1);
        chk("abort_byte2", gpio_out[23:16], 8'hFE);
        rst = 1'b0;
        #1;
        chk("abort_gpio", gpio_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        m_last = NREQ - 1;
        run_txn(mk(3'b110, 16'h0088, 32'h00005AA5, 3'd2, 1, 11), "post_abort");

        // Random traffic against the round-robin / serialisation model.
        for (int it = 0; it < 40; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                v.addr[i] = 16'($urandom);
                v.data[i] = $urandom;
                v.nb[i]   = 3'($urandom_range(0, 7));
            end
            v.mask = mask;
            v.exp_grant = rr(mask, m_last);
            n = clampn(v.nb[v.exp_grant]);
            v.exp_lat = (n == 0) ? 1 : n * (1 + 2 * HOLD) + 1;
            run_txn(v, $sformatf("rnd%0d", it));
        end

        chk("ready_onehot", bad_ready, 0);
        chk("wclk_only_when_busy", bad_wclk, 0);
        chk("gpio_upper_zero", bad_hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
